// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: store size, load type, writeback
// source and the bus-wait FSM state.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    WDIN_WORD = 2'b00,
    WDIN_HALF = 2'b01,
    WDIN_BYTE = 2'b10
  } wdin_op_t;

  typedef enum logic [2:0] {
    RB_LW  = 3'b000,
    RB_LH  = 3'b001,
    RB_LHU = 3'b010,
    RB_LB  = 3'b011,
    RB_LBU = 3'b100
  } rb_op_t;

  typedef enum logic [1:0] {
    WSEL_C    = 2'b00,
    WSEL_LOAD = 2'b01,
    WSEL_PC4  = 2'b10,
    WSEL_EXT  = 2'b11
  } rf_wsel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data bus between the MEM stage (master) and memory (slave).
// Handshake: a transfer completes on a rising edge where req and ready are
// both high; while req is high without ready, addr/we/wdata/be stay stable.
interface mem_wb_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_wb_stage_lane_fmt.sv
// Byte-lane formatting: store byte enables / lane replication and
// load lane selection with sign or zero extension.
module mem_lane_fmt
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  wdin_op,
  input  logic [2:0]  rb_op,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (wdin_op)
      WDIN_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      WDIN_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (rb_op)
      RB_LH:   load_data = {{16{half_v[15]}}, half_v};
      RB_LHU:  load_data = {16'h0000, half_v};
      RB_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      RB_LBU:  load_data = {24'h000000, byte_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data-bus access with wait-state FSM, timeout and
// MEM/WB register. Optional alignment check enabled by MEM_ALIGN_CHECK_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_C,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_ext,
  input  logic [31:0] mem_rD2,
  input  logic [31:0] mem_pc,
  input  logic [1:0]  mem_ram_wdin_op,
  input  logic [2:0]  mem_ram_rb_op,
  input  logic        mem_ram_we,
  input  logic        mem_rf_we,
  input  logic [1:0]  mem_rf_wsel,
  input  logic [4:0]  mem_wR,
  mem_wb_stage_if.master dbus,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [4:0]  wb_wR,
  output logic [31:0] wb_wD,
  output logic [31:0] wb_pc,
  output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output state_t      fsm_state
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          access, access_eff, misal, timeout_now;
  logic [31:0]   load_data, wd_next;

  assign access = mem_valid & (mem_ram_we | (mem_rf_wsel == WSEL_LOAD));

`ifdef MEM_ALIGN_CHECK_EN
  logic store_mis, load_mis, ld_half, ld_byte;
  always_comb begin
    ld_half   = (mem_ram_rb_op == RB_LH) | (mem_ram_rb_op == RB_LHU);
    ld_byte   = (mem_ram_rb_op == RB_LB) | (mem_ram_rb_op == RB_LBU);
    store_mis = mem_ram_we &
                (((mem_ram_wdin_op == WDIN_HALF) & mem_C[0]) |
                 ((mem_ram_wdin_op != WDIN_HALF) & (mem_ram_wdin_op != WDIN_BYTE) &
                  (mem_C[1:0] != 2'b00)));
    load_mis  = (mem_rf_wsel == WSEL_LOAD) &
                ((ld_half & mem_C[0]) | (~ld_half & ~ld_byte & (mem_C[1:0] != 2'b00)));
    misal     = access & (state == ST_IDLE) & (store_mis | load_mis);
  end
`else
  assign misal = 1'b0;
`endif

  assign access_eff  = access & ~misal;
  // The timeout cycle drops req so the stall releases and the slot retires.
  assign timeout_now = (state == ST_WAIT) & ~dbus.ready & (wait_cnt == CNT_LAST);
  assign dbus.req    = ~rst & (((state == ST_IDLE) & access_eff) |
                               ((state == ST_WAIT) & ~timeout_now));
  assign dbus.we     = dbus.req & mem_ram_we;
  assign dbus.addr   = {mem_C[31:2], 2'b00};
  assign mem_stall   = dbus.req & ~dbus.ready;
  assign fsm_state   = state;

  mem_lane_fmt u_lane_fmt (
    .lane       (mem_C[1:0]),
    .wdin_op    (mem_ram_wdin_op),
    .rb_op      (mem_ram_rb_op),
    .store_data (mem_rD2),
    .rdata      (dbus.rdata),
    .be         (dbus.be),
    .wdata      (dbus.wdata),
    .load_data  (load_data)
  );

  always_comb begin
    case (mem_rf_wsel)
      WSEL_C:    wd_next = mem_C;
      WSEL_LOAD: wd_next = load_data;
      WSEL_PC4:  wd_next = mem_pc4;
      default:   wd_next = mem_ext;
    endcase
    if (timeout_now) wd_next = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access_eff & ~dbus.ready) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (dbus.ready) begin
            state <= ST_IDLE;
          end else if (timeout_now) begin
            state    <= ST_IDLE;
            bus_err  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rf_we <= 1'b0;
      wb_wR    <= 5'd0;
      wb_wD    <= 32'h0;
      wb_pc    <= 32'h0;
    end else if (!mem_stall) begin
      wb_valid <= mem_valid & ~misal;
      wb_rf_we <= mem_valid & mem_rf_we & (mem_wR != 5'd0) & ~misal;
      wb_wR    <= mem_wR;
      wb_wD    <= wd_next;
      wb_pc    <= mem_pc;
    end else begin
      wb_valid <= 1'b0;
      wb_rf_we <= 1'b0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= misal;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage with a lane/latency reference
// model; a separate monitor checks every MEM/WB writeback.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ram_we, mem_rf_we;
  logic [31:0] mem_C, mem_pc4, mem_ext, mem_rD2, mem_pc;
  logic [1:0]  mem_ram_wdin_op, mem_rf_wsel;
  logic [2:0]  mem_ram_rb_op;
  logic [4:0]  mem_wR;
  logic        mem_stall, wb_valid, wb_rf_we, bus_err;
  logic [4:0]  wb_wR;
  logic [31:0] wb_wD, wb_pc;
  state_t      fsm_state;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  mem_wb_stage_if dbus_i ();

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_C(mem_C), .mem_pc4(mem_pc4),
    .mem_ext(mem_ext), .mem_rD2(mem_rD2), .mem_pc(mem_pc),
    .mem_ram_wdin_op(mem_ram_wdin_op), .mem_ram_rb_op(mem_ram_rb_op),
    .mem_ram_we(mem_ram_we), .mem_rf_we(mem_rf_we), .mem_rf_wsel(mem_rf_wsel),
    .mem_wR(mem_wR), .dbus(dbus_i), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_rf_we(wb_rf_we), .wb_wR(wb_wR), .wb_wD(wb_wD), .wb_pc(wb_pc),
    .bus_err(bus_err),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [69:0] exp_q[$];
  logic [69:0] mon_e;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [3:0] exp_be(input logic [1:0] wdin, input logic [31:0] c);
    case (wdin)
      2'b01:   return 4'b0011 << (2 * c[1]);
      2'b10:   return 4'b0001 << c[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] wdin, input logic [31:0] d);
    case (wdin)
      2'b01:   return d[15:0] * 32'h0001_0001;
      2'b10:   return d[7:0] * 32'h0101_0101;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] rb, input logic [31:0] c,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * c[1:0])) & 32'hFF;
    h = (w >> (16 * c[1])) & 32'hFFFF;
    case (rb)
      3'd1:    return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  // driver: issues one slot, models bus latency and pushes the expected writeback
  task automatic issue(input logic v, input logic [31:0] c, input logic we_m,
                       input logic [1:0] wsel, input logic [1:0] wdin, input logic [2:0] rb,
                       input logic [4:0] wr, input logic rfwe, input logic [31:0] rd2,
                       input int dly, input logic [31:0] rd_word);
    logic        acc, tout;
    int          done_k;
    logic [31:0] pc, ext, wd;
    pc  = $urandom;
    ext = $urandom;
    mem_valid = v; mem_C = c; mem_ram_we = we_m; mem_rf_wsel = wsel;
    mem_ram_wdin_op = wdin; mem_ram_rb_op = rb; mem_wR = wr; mem_rf_we = rfwe;
    mem_rD2 = rd2; mem_pc = pc; mem_pc4 = pc + 32'd4; mem_ext = ext;
    acc    = v && (we_m || wsel == 2'b01);
    tout   = acc && (dly > TO);
    done_k = !acc ? 0 : (tout ? TO : dly);
    case (wsel)
      2'b00:   wd = c;
      2'b01:   wd = load_model(rb, c, rd_word);
      2'b10:   wd = pc + 32'd4;
      default: wd = ext;
    endcase
    if (tout) wd = 32'h0;
    if (v) exp_q.push_back({rfwe && (wr != 5'd0), wr, wd, pc});
    for (int k = 0; k <= done_k; k++) begin
      dbus_i.ready = acc ? (k == dly) : 1'($urandom_range(0, 1));
      dbus_i.rdata = (k == dly) ? rd_word : $urandom;
      @(negedge clk);
      chk("state", fsm_state, (k == 0) ? ST_IDLE : ST_WAIT);
      chk("req", dbus_i.req, acc && !(tout && k == TO));
      chk("stall", mem_stall, k < done_k);
      chk("bus_err", bus_err, exp_err);
      if (dbus_i.req) begin
        chk("addr", dbus_i.addr, {c[31:2], 2'b00});
        chk("we", dbus_i.we, we_m);
        if (we_m) begin
          chk("be", dbus_i.be, exp_be(wdin, c));
          chk("wdata", dbus_i.wdata, exp_wdata(wdin, rd2));
        end
      end
      @(posedge clk);
      #1;
    end
    if (tout) exp_err = 1'b1;
  endtask

  task automatic issue_rand();
    issue(1'($urandom_range(0, 7) != 0), $urandom, 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 4)),
          5'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TO), $urandom);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got writeback pc %h expected none", wb_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_rf_we", wb_rf_we, mon_e[69]);
        chk("wb_wR", wb_wR, mon_e[68:64]);
        chk("wb_wD", wb_wD, mon_e[63:32]);
        chk("wb_pc", wb_pc, mon_e[31:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_valid = 0; mem_C = 0; mem_ram_we = 0; mem_rf_wsel = 0; mem_ram_wdin_op = 0;
    mem_ram_rb_op = 0; mem_wR = 0; mem_rf_we = 0; mem_rD2 = 0; mem_pc = 0; mem_pc4 = 0;
    mem_ext = 0; dbus_i.ready = 0; dbus_i.rdata = 0;
    @(negedge clk);
    chk("rst_state", fsm_state, ST_IDLE);
    chk("rst_req", dbus_i.req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_rf_we", wb_rf_we, 1'b0);
    chk("rst_wb_wD", wb_wD, 32'h0);
    chk("rst_wb_pc", wb_pc, 32'h0);
    chk("rst_wb_wR", wb_wR, 5'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // sb zero-wait, lb/lbu sign handling, lw with 3 wait states, sh upper lane
    issue(1, 32'h1002, 1, 2'b00, 2'b10, 3'd0, 5'd0, 0, 32'h0000_00AB, 0, $urandom);
    issue(1, 32'h1003, 0, 2'b01, 2'b00, 3'd3, 5'd7, 1, $urandom, 0, 32'h80FF_0000);
    issue(1, 32'h1003, 0, 2'b01, 2'b00, 3'd4, 5'd8, 1, $urandom, 1, 32'h80FF_0000);
    issue(1, 32'h1000, 0, 2'b01, 2'b00, 3'd0, 5'd9, 1, $urandom, 3, 32'hDEAD_BEEF);
    issue(1, 32'h2006, 1, 2'b00, 2'b01, 3'd0, 5'd0, 0, 32'h1234_5678, 2, $urandom);
    issue(1, 32'h2002, 0, 2'b01, 2'b00, 3'd1, 5'd0, 1, $urandom, TO, 32'h9ABC_0000);
    issue(1, 32'h3000, 0, 2'b10, 2'b00, 3'd0, 5'd4, 1, $urandom, 0, $urandom);

`ifdef MEM_ALIGN_CHECK_EN
    mem_valid = 1; mem_ram_we = 0; mem_rf_wsel = 2'b01; mem_ram_rb_op = 3'd1;
    mem_C = 32'h1001; mem_rf_we = 1; mem_wR = 5'd3; dbus_i.ready = 0;
    @(negedge clk);
    chk("mis_req", dbus_i.req, 1'b0);
    chk("mis_stall", mem_stall, 1'b0);
    @(posedge clk);
    #1 mem_valid = 0;
    @(negedge clk);
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_rf_we", wb_rf_we, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mis_pulse_end", misalign, 1'b0);
    @(posedge clk);
    #1;
`endif

    repeat (200) issue_rand();

    // bus never answers: timeout, then bus_err must stay set
    issue(1, 32'h4000, 0, 2'b01, 2'b00, 3'd0, 5'd10, 1, $urandom, 1000, $urandom);
    chk("tout_state", fsm_state, ST_IDLE);
    repeat (5) issue_rand();

    // reset in the middle of a WAIT
    mem_valid = 1; mem_ram_we = 0; mem_rf_wsel = 2'b01; mem_ram_rb_op = 3'd0;
    mem_C = 32'h5000; mem_rf_we = 1; mem_wR = 5'd5; dbus_i.ready = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_state", fsm_state, ST_WAIT);
    #2 rst = 1'b1;
    mem_valid = 0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", dbus_i.req, 1'b0);
    chk("mid_rst_wb_valid", wb_valid, 1'b0);
    chk("mid_rst_bus_err", bus_err, 1'b0);
    chk("mid_rst_state", fsm_state, ST_IDLE);
    @(posedge clk);
    #1 rst = 1'b0;

    repeat (20) issue_rand();
    issue(0, 0, 0, 2'b00, 2'b00, 3'd0, 5'd0, 0, 0, 0, 0);
    issue(0, 0, 0, 2'b00, 2'b00, 3'd0, 5'd0, 0, 0, 0, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum bus-wait cycles before an error is flagged.
REQ-002 Clock is clk, one clock; reset is rst, asynchronous, active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 mem_valid  in  1  EX/MEM slot holds a real instruction.
REQ-006 mem_C, mem_pc4, mem_ext, mem_rD2, mem_pc  in  32 each  ALU result/address, PC+4, immediate, store data, PC.
REQ-007 mem_ram_wdin_op  in  2  store size: 00 word, 01 half, 10 byte.
REQ-008 mem_ram_rb_op  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
REQ-009 mem_ram_we, mem_rf_we  in  1 each  memory write, register write enables.
REQ-010 mem_rf_wsel  in  2  writeback source: 00 C, 01 load, 10 pc4, 11 ext.
REQ-011 mem_wR  in  5  destination register.
REQ-012 dbus_req, dbus_we  out  1 each  bus request, write strobe.
REQ-013 dbus_addr, dbus_wdata  out  32 each  word-aligned address (C[31:2],00), lane-replicated write data.
REQ-014 dbus_be  out  4  byte enables.
REQ-015 dbus_ready  in  1; dbus_rdata  in  32  bus completion, read word.
REQ-016 mem_stall  out  1  freezes all upstream stages.
REQ-017 wb_valid, wb_rf_we  out  1 each; wb_wR  out  5; wb_wD, wb_pc  out  32 each  MEM/WB register.
REQ-018 bus_err  out  1  sticky timeout flag.

Function
REQ-019 Memory access = mem_valid & (mem_ram_we | mem_rf_wsel==01); all other valid instructions pass in one cycle, no bus request.
REQ-020 FSM states IDLE, WAIT; IDLE->WAIT on memory access with dbus_ready low; WAIT->IDLE when dbus_ready high.
REQ-021 dbus_req asserted combinationally in IDLE on memory access and held in WAIT; address/data/be stable while asserted.
REQ-022 Zero-wait access (dbus_ready high in same cycle) completes in one cycle, no stall.
REQ-023 mem_stall = dbus_req & ~dbus_ready.
REQ-024 Store be: word 1111; half 0011/1100 by C[1]; byte 0001<<C[1:0]; wdata replicates rD2 low half/byte across lanes.
REQ-025 Load extraction selects lane by C[1:0]; lh/lb sign-extend, lhu/lbu zero-extend, lw passes whole word.
REQ-026 MEM/WB register loads on every rising edge where mem_stall low; while stalled, wb_valid and wb_rf_we load 0 (bubble), other fields hold.
REQ-027 wb_rf_we = mem_valid & mem_rf_we & (mem_wR!=0).
REQ-028 Wait counter increments each WAIT cycle; reaching TIMEOUT sets bus_err, forces completion with wb_wD=0, returns to IDLE.
REQ-029 bus_err cleared only by rst.

Reset
REQ-030 rst forces IDLE, wait counter 0, bus_err 0, all wb_* outputs 0, dbus_req 0, mem_stall 0.
REQ-031 rst during WAIT abandons the access; no writeback issued for it.

Configuration
REQ-032 Macro MEM_ALIGN_CHECK_EN: when defined, misaligned access (half with C[0]=1, word with C[1:0]!=00) suppresses dbus_req, writes back nothing (wb_rf_we=0) and pulses output misalign (1 bit) for one cycle; when undefined, port misalign absent and addresses are used as given with low bits ignored per REQ-024/025.

Structure
REQ-033 Shared package holds wdin_op, rb_op and rf_wsel encodings and FSM state typedef.
REQ-034 Combinational sub-module mem_lane_fmt implements REQ-024 and REQ-025.

Verification
REQ-035 sb C=0x1002, rD2=0x000000AB, ready=1 -> be=0100, wdata=0xABABABAB, no stall.
REQ-036 lb C=0x1003, rdata=0x80FF_0000 -> wb_wD=0xFFFFFF80; lbu -> 0x00000080.
REQ-037 lw with ready after 3 cycles -> mem_stall high 3 cycles, 3 bubbles, then wb_wD=rdata.
REQ-038 ready never asserted, TIMEOUT=4 -> bus_err=1 after 4 WAIT cycles, wb_wD=0, FSM IDLE.
REQ-039 rst asserted mid-WAIT -> next cycle dbus_req=0, wb_valid=0, bus_err=0.
REQ-040 MEM_ALIGN_CHECK_EN, lh C=0x1001 -> dbus_req=0, misalign pulse, wb_rf_we=0.
